// File: rtl/spi_flash_model.sv
// rtl/spi_flash_model.sv - oversampled SPI NOR flash slave model with word prefetch
module spi_flash_model #(
  parameter int          ADDR_BYTES   = 3,
  parameter int          WORD_BYTES   = 4,
  parameter int          DUMMY_CYCLES = 8,
  parameter logic [23:0] JEDEC_ID     = 24'hEF4018,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    sck,
  input  logic                    ss,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    mem_req,
  output logic [8*ADDR_BYTES-1:0] mem_addr,
  input  logic                    mem_rvalid,
  input  logic [8*WORD_BYTES-1:0] mem_rdata,
  output logic                    err_cmd,
  output logic                    err_underrun
);

  localparam int AW  = 8 * ADDR_BYTES;
  localparam int DW  = 8 * WORD_BYTES;
  localparam int BOW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [AW-1:0]  ALIGN_MASK = ~(AW'(WORD_BYTES - 1));
  localparam logic [BOW-1:0] LAST_BYTE  = BOW'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_ID, S_STAT, S_ERR
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic                   sck_d;
  logic                   sck_s, ss_s, mosi_s, rise, fall;
  logic [15:0]            bit_cnt;
  logic [2:0]             tx_bit;
  logic [1:0]             id_idx;
  logic [BOW-1:0]         byte_idx;
  logic [AW-1:0]          shift_in, shift_next;
  logic [7:0]             tx_sr;
  logic                   is_fast, pending, word_valid, resp, avail;
  logic [DW-1:0]          word_buf, avail_word;
  logic [7:0]             cur_byte, id_byte, load_byte;

  // Pin synchronizers plus the previous synced sck for edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      sck_sync  <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
    end else begin
      sck_sync[0]  <= sck;
      ss_sync[0]   <= ss;
      mosi_sync[0] <= mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sck_sync[i]  <= sck_sync[i-1];
        ss_sync[i]   <= ss_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
      end
      sck_d <= sck_s;
    end
  end

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign ss_s       = ss_sync[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign rise       = sck_s & ~sck_d;
  assign fall       = ~sck_s & sck_d;
  assign shift_next = {shift_in[AW-2:0], mosi_s};

  // Byte selection; a response arriving on the load cycle is forwarded directly
  always_comb begin
    resp       = pending & mem_rvalid;
    avail      = word_valid | resp;
    avail_word = word_valid ? word_buf : mem_rdata;
    cur_byte   = 8'hFF;
    for (int k = 0; k < WORD_BYTES; k++)
      if (byte_idx == BOW'(k)) cur_byte = avail_word[8*k +: 8];
    case (id_idx)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      default: id_byte = JEDEC_ID[7:0];
    endcase
    case (state)
      S_DATA:  load_byte = avail ? cur_byte : 8'hFF;
      S_ID:    load_byte = id_byte;
      default: load_byte = 8'h00;
    endcase
  end

  // Command FSM, fetch bookkeeping and miso shifter
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      miso         <= 1'b1;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      err_cmd      <= 1'b0;
      err_underrun <= 1'b0;
      bit_cnt      <= '0;
      tx_bit       <= '0;
      id_idx       <= '0;
      byte_idx     <= '0;
      shift_in     <= '0;
      tx_sr        <= 8'hFF;
      is_fast      <= 1'b0;
      pending      <= 1'b0;
      word_valid   <= 1'b0;
      word_buf     <= '0;
    end else begin
      mem_req <= 1'b0;
      if (resp) begin
        word_buf   <= mem_rdata;
        word_valid <= 1'b1;
        pending    <= 1'b0;
      end
      if (ss_s) begin
        state      <= S_IDLE;
        miso       <= 1'b1;
        bit_cnt    <= '0;
        tx_bit     <= '0;
        id_idx     <= '0;
        byte_idx   <= '0;
        shift_in   <= '0;
        tx_sr      <= 8'hFF;
        pending    <= 1'b0;
        word_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state   <= S_CMD;
            bit_cnt <= '0;
            miso    <= 1'b1;
          end
          S_CMD: if (rise) begin
            shift_in <= shift_next;
            if (bit_cnt == 16'd7) begin
              bit_cnt <= '0;
              tx_bit  <= '0;
              id_idx  <= '0;
              case (shift_next[7:0])
                8'h03: begin state <= S_ADDR; is_fast <= 1'b0; end
                8'h0B: begin state <= S_ADDR; is_fast <= 1'b1; end
                8'h9F: state <= S_ID;
                8'h05: state <= S_STAT;
                default: begin state <= S_ERR; err_cmd <= 1'b1; end
              endcase
            end else begin
              bit_cnt <= bit_cnt + 16'd1;
            end
          end
          S_ADDR: if (rise) begin
            shift_in <= shift_next;
            if (bit_cnt == 16'(AW - 1)) begin
              bit_cnt    <= '0;
              tx_bit     <= '0;
              mem_req    <= 1'b1;
              mem_addr   <= shift_next & ALIGN_MASK;
              byte_idx   <= shift_next[BOW-1:0] & LAST_BYTE;
              pending    <= 1'b1;
              word_valid <= 1'b0;
              state      <= (is_fast && DUMMY_CYCLES > 0) ? S_DUMMY : S_DATA;
            end else begin
              bit_cnt <= bit_cnt + 16'd1;
            end
          end
          S_DUMMY: if (rise) begin
            if (bit_cnt == 16'(DUMMY_CYCLES - 1)) begin
              bit_cnt <= '0;
              state   <= S_DATA;
            end else begin
              bit_cnt <= bit_cnt + 16'd1;
            end
          end
          S_DATA, S_ID, S_STAT: if (fall) begin
            tx_bit <= tx_bit + 3'd1;
            if (tx_bit == 3'd0) begin
              miso  <= load_byte[7];
              tx_sr <= {load_byte[6:0], 1'b1};
              if (state == S_DATA) begin
                if (!avail) begin
                  err_underrun <= 1'b1;
                end else if (byte_idx == LAST_BYTE) begin
                  byte_idx   <= '0;
                  word_valid <= 1'b0;
                  pending    <= 1'b1;
                  mem_req    <= 1'b1;
                  mem_addr   <= mem_addr + AW'(WORD_BYTES);
                end else begin
                  byte_idx <= byte_idx + BOW'(1);
                end
              end else if (state == S_ID) begin
                id_idx <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
              end
            end else begin
              miso  <= tx_sr[7];
              tx_sr <= {tx_sr[6:0], 1'b1};
            end
          end
          default: miso <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_model.sv
// tb/tb_spi_flash_model.sv - directed self-checking bench for spi_flash_model
module tb_spi_flash_model;

  logic        clock = 1'b0;
  logic        reset;
  logic        sck, ss, mosi, miso;
  logic        mem_req, mem_rvalid;
  logic [23:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        err_cmd, err_underrun;

  int          errors = 0;
  int          checks = 0;
  int          resp_delay = 1;
  logic [23:0] req_log[$];

  spi_flash_model dut (
    .clock(clock), .reset(reset), .sck(sck), .ss(ss), .mosi(mosi), .miso(miso),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err_cmd(err_cmd), .err_underrun(err_underrun)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    case (a)
      24'h000000: return 32'h03020100;
      24'h000004: return 32'h44332211;
      24'h000008: return 32'h88776655;
      24'h00000C: return 32'hCCBBAA99;
      24'hFFFFFC: return 32'hDDCCBBAA;
      default:    return 32'hDEADBEEF;
    endcase
  endfunction

  // Backing store: answer each fetch after resp_delay clocks
  initial begin
    logic [23:0] a;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clock);
      if (mem_req) begin
        a = mem_addr;
        req_log.push_back(a);
        repeat (resp_delay) @(negedge clock);
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(a);
        @(negedge clock);
        mem_rvalid = 1'b0;
      end
    end
  end

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      #40 sck = 1'b1;
      rx[i] = miso;
      #40 sck = 1'b0;
    end
  endtask

  task automatic begin_xfer(input logic [7:0] cmd);
    logic [7:0] rx;
    ss = 1'b0;
    #40;
    spi_byte(cmd, rx);
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [7:0] rx;
    spi_byte(a[23:16], rx);
    spi_byte(a[15:8], rx);
    spi_byte(a[7:0], rx);
  endtask

  task automatic end_xfer();
    #40 ss = 1'b1;
    #120;
  endtask

  task automatic test_reset();
    reset = 1'b1; ss = 1'b1; sck = 1'b0; mosi = 1'b0;
    #100 reset = 1'b0;
    #20;
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL reset_miso got=%b exp=1", miso); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if (mem_addr !== 24'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=000000", mem_addr); end
    checks++; if (err_cmd !== 1'b0) begin errors++; $display("FAIL reset_err_cmd got=%b exp=0", err_cmd); end
    checks++; if (err_underrun !== 1'b0) begin errors++; $display("FAIL reset_err_underrun got=%b exp=0", err_underrun); end
  endtask

  task automatic test_read_aligned();
    logic [7:0]  rx;
    logic [63:0] exp = 64'h1122334455667788;
    req_log.delete();
    begin_xfer(8'h03);
    send_addr(24'h000004);
    for (int i = 0; i < 8; i++) begin
      spi_byte(8'h00, rx);
      checks++;
      if (rx !== exp[63-8*i -: 8]) begin
        errors++; $display("FAIL read4_byte%0d got=%h exp=%h", i, rx, exp[63-8*i -: 8]);
      end
    end
    end_xfer();
    checks++; if (req_log.size() < 2) begin errors++; $display("FAIL read4_req_count got=%0d exp>=2", req_log.size()); end
    else begin
      checks++; if (req_log[0] !== 24'h000004) begin errors++; $display("FAIL read4_addr0 got=%h exp=000004", req_log[0]); end
      checks++; if (req_log[1] !== 24'h000008) begin errors++; $display("FAIL read4_addr1 got=%h exp=000008", req_log[1]); end
    end
    checks++; if (err_underrun !== 1'b0 || err_cmd !== 1'b0) begin
      errors++; $display("FAIL read4_flags got=%b%b exp=00", err_cmd, err_underrun);
    end
  endtask

  task automatic test_read_offset();
    logic [7:0]  rx;
    logic [31:0] exp = 32'h33445566;
    req_log.delete();
    begin_xfer(8'h03);
    send_addr(24'h000006);
    checks++; if (req_log.size() != 1 || req_log[0] !== 24'h000004) begin
      errors++; $display("FAIL read6_first_fetch got_count=%0d exp_count=1 addr exp=000004", req_log.size());
    end
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'h00, rx);
      checks++;
      if (rx !== exp[31-8*i -: 8]) begin
        errors++; $display("FAIL read6_byte%0d got=%h exp=%h", i, rx, exp[31-8*i -: 8]);
      end
      if (i == 0) begin
        #40;
        checks++; if (req_log.size() != 2 || req_log[1] !== 24'h000008) begin
          errors++; $display("FAIL read6_prefetch got_count=%0d exp_count=2 addr exp=000008", req_log.size());
        end
      end
    end
    end_xfer();
  endtask

  task automatic test_fast_read();
    logic [7:0]  rx;
    logic [31:0] exp = 32'hAABBCCDD;
    req_log.delete();
    begin_xfer(8'h0B);
    send_addr(24'hFFFFFC);
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'hFF) begin errors++; $display("FAIL fast_dummy got=%h exp=ff", rx); end
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'h00, rx);
      checks++;
      if (rx !== exp[31-8*i -: 8]) begin
        errors++; $display("FAIL fast_byte%0d got=%h exp=%h", i, rx, exp[31-8*i -: 8]);
      end
    end
    #40;
    checks++; if (req_log.size() != 2 || req_log[0] !== 24'hFFFFFC || req_log[1] !== 24'h000000) begin
      errors++; $display("FAIL fast_wrap_fetch got_count=%0d exp_count=2 addrs exp=fffffc,000000", req_log.size());
    end
    end_xfer();
  endtask

  task automatic test_id_status();
    logic [7:0]  rx;
    logic [39:0] exp = 40'hEF4018EF40;
    begin_xfer(8'h9F);
    for (int i = 0; i < 5; i++) begin
      spi_byte(8'h00, rx);
      checks++;
      if (rx !== exp[39-8*i -: 8]) begin
        errors++; $display("FAIL id_byte%0d got=%h exp=%h", i, rx, exp[39-8*i -: 8]);
      end
    end
    end_xfer();
    begin_xfer(8'h05);
    for (int i = 0; i < 2; i++) begin
      spi_byte(8'h00, rx);
      checks++; if (rx !== 8'h00) begin errors++; $display("FAIL stat_byte%0d got=%h exp=00", i, rx); end
    end
    end_xfer();
  endtask

  task automatic test_bad_cmd();
    logic [7:0] rx;
    begin_xfer(8'h02);
    for (int i = 0; i < 2; i++) begin
      spi_byte(8'hA5, rx);
      checks++; if (rx !== 8'hFF) begin errors++; $display("FAIL err_miso%0d got=%h exp=ff", i, rx); end
    end
    checks++; if (err_cmd !== 1'b1) begin errors++; $display("FAIL err_cmd_set got=%b exp=1", err_cmd); end
    end_xfer();
    begin_xfer(8'h03);
    send_addr(24'h000008);
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'h55) begin errors++; $display("FAIL after_err_byte0 got=%h exp=55", rx); end
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'h66) begin errors++; $display("FAIL after_err_byte1 got=%h exp=66", rx); end
    end_xfer();
    checks++; if (err_cmd !== 1'b1) begin errors++; $display("FAIL err_cmd_sticky got=%b exp=1", err_cmd); end
  endtask

  task automatic test_underrun();
    logic [7:0] rx;
    resp_delay = 20;
    begin_xfer(8'h03);
    send_addr(24'h000000);
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'hFF) begin errors++; $display("FAIL underrun_byte got=%h exp=ff", rx); end
    checks++; if (err_underrun !== 1'b1) begin errors++; $display("FAIL underrun_flag got=%b exp=1", err_underrun); end
    end_xfer();
    #300;
    resp_delay = 1;
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    req_log.delete();
    begin_xfer(8'h03);
    spi_byte(8'h00, rx);
    end_xfer();
    checks++; if (req_log.size() != 0) begin errors++; $display("FAIL abort_no_fetch got=%0d exp=0", req_log.size()); end
    begin_xfer(8'h03);
    send_addr(24'h000004);
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'h11) begin errors++; $display("FAIL abort_next_byte0 got=%h exp=11", rx); end
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'h22) begin errors++; $display("FAIL abort_next_byte1 got=%h exp=22", rx); end
    end_xfer();
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    begin_xfer(8'h03);
    send_addr(24'h000004);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    #40;
    reset = 1'b1; ss = 1'b1;
    #20;
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL midreset_miso got=%b exp=1", miso); end
    checks++; if (err_cmd !== 1'b0 || err_underrun !== 1'b0) begin
      errors++; $display("FAIL midreset_flags got=%b%b exp=00", err_cmd, err_underrun);
    end
    reset = 1'b0;
    #100;
    begin_xfer(8'h05);
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL postreset_stat got=%h exp=00", rx); end
    end_xfer();
  endtask

  initial begin
    test_reset();
    test_read_aligned();
    test_read_offset();
    test_fast_read();
    test_id_status();
    test_bad_cmd();
    test_underrun();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
